// File: rtl/banco_reg.sv
// Register file: 31 storage registers plus hardwired zero, two combinational
// read ports with write-through bypass, and a committed-write counter.
module banco_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [15:0]       wr_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [1:NREG-1];
   logic [15:0]       r_wr_cnt;
   logic              w_commit;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   // Writes to address 0 are dropped here, so they neither store nor count.
   assign w_commit = we && (wa != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (w_commit && (wa == ADDR_W'(i))) begin
               r_regs[i] <= wd;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt <= '0;
      end else if (w_commit) begin
         r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   // Read mux: address 0 falls through to the zero default. Bypass takes
   // priority over storage, and reset forces zero over everything.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (ra1 == ADDR_W'(i)) w_rd1 = r_regs[i];
         if (ra2 == ADDR_W'(i)) w_rd2 = r_regs[i];
      end
      if (w_commit && (wa == ra1)) w_rd1 = wd;
      if (w_commit && (wa == ra2)) w_rd2 = wd;
      if (!rst_n) begin
         w_rd1 = '0;
         w_rd2 = '0;
      end
   end

   assign rd1    = w_rd1;
   assign rd2    = w_rd2;
   assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_banco_reg.sv
// Directed bench for banco_reg: table of single-cycle vectors checked before
// and after the edge, plus reset, first-write and counter-wrap sequences.
module tb_banco_reg;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] rd1, rd2, wd;
   logic        we;
   logic [15:0] wr_cnt;

   int n_pass = 0;
   int n_total = 0;

   banco_reg #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ra1    (ra1),
      .ra2    (ra2),
      .rd1    (rd1),
      .rd2    (rd2),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .wr_cnt (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp_rd1;
      logic [31:0] exp_rd2;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   initial begin
      // expected rd is the same before the edge (bypass) and after it (stored)
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        16'd1};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 16'd1};
      vecs[3] = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd0,  32'h00000001, 32'h0,        16'd2};
      vecs[4] = '{1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 16'd3};
      vecs[5] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 16'd4};
      vecs[6] = '{1'b1, 5'd7,  32'h0BADF00D, 5'd7,  5'd5,  32'h0BADF00D, 32'hDEADBEEF, 16'd5};
      vecs[7] = '{1'b0, 5'd31, 32'h00000055, 5'd31, 5'd7,  32'h0,        32'h0BADF00D, 16'd5};
      vecs[8] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd1,  32'h11111111, 32'h11111111, 16'd6};
      vecs[9] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd0,  5'd31, 32'h0,        32'hA5A5A5A5, 16'd7};

      rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_cnt", {16'h0, wr_cnt}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         #1;
         check($sformatf("init_rd1_a%0d", a), rd1, 32'h0);
         check($sformatf("init_rd2_a%0d", 31 - a), rd2, 32'h0);
      end
      check("init_cnt", {16'h0, wr_cnt}, 32'h0);

      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
         ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
         #1;
         check($sformatf("v%0d_pre_rd1", v), rd1, vecs[v].exp_rd1);
         check($sformatf("v%0d_pre_rd2", v), rd2, vecs[v].exp_rd2);
         @(posedge clk);
         #1;
         we = 1'b0;
         #1;
         check($sformatf("v%0d_post_rd1", v), rd1, vecs[v].exp_rd1);
         check($sformatf("v%0d_post_rd2", v), rd2, vecs[v].exp_rd2);
         check($sformatf("v%0d_cnt", v), {16'h0, wr_cnt}, {16'h0, vecs[v].exp_cnt});
      end

      // Mid-cycle reset clears storage and counter without a clock edge.
      ra1 = 5'd31; ra2 = 5'd5;
      #1;
      check("pre_rst_r31", rd1, 32'hA5A5A5A5);
      rst_n = 1'b0;
      #1;
      check("rst_async_r31", rd1, 32'h0);
      check("rst_async_r5", rd2, 32'h0);
      check("rst_async_cnt", {16'h0, wr_cnt}, 32'h0);
      we = 1'b1; wa = 5'd9; wd = 32'h77777777; ra1 = 5'd9;
      #1;
      check("rst_no_bypass", rd1, 32'h0);
      @(posedge clk);
      #1;
      check("rst_write_ignored_cnt", {16'h0, wr_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; we = 1'b0;
      #1;
      check("rst_write_lost", rd1, 32'h0);

      // First write lands on the first edge with reset released.
      we = 1'b1; wa = 5'd9; wd = 32'h99999999;
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      check("first_write_r9", rd1, 32'h99999999);
      check("first_write_cnt", {16'h0, wr_cnt}, 32'h1);

      // Counter wrap: 65537 writes to address 3 from a fresh reset.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      ra1 = 5'd3; ra2 = 5'd9;
      for (int n = 1; n <= 65537; n++) begin
         @(negedge clk);
         we = 1'b1; wa = 5'd3; wd = 32'(n) ^ 32'h5A000000;
         @(posedge clk);
         #1;
         if (n == 65535) check("cnt_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
         if (n == 65536) check("cnt_wrap0", {16'h0, wr_cnt}, 32'h0);
      end
      we = 1'b0;
      #1;
      check("wrap_cnt", {16'h0, wr_cnt}, 32'h1);
      check("wrap_r3_last", rd1, 32'h5A010001);
      check("wrap_r9_cleared", rd2, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
